ascii_uart_tx: RTL and testbench
================================

Name: ascii_uart_tx

Overview:
Downstream serial stage for the two-digit ASCII counter word. Latches a 16-bit word holding two ASCII characters (tens in [15:8], ones in [7:0]) on a send request. Transmits the two characters, optionally followed by CR LF, as 8N1 RS-232 frames on a single TX line. Drives the board UART pin directly.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); legal range 2..65535.
- SEND_CRLF, 1, 1 = append 0x0D, 0x0A after the two characters; 0 = two characters only.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  16  ASCII pair; [15:8] is sent first, [7:0] second.
- send  input  1  transmit request, sampled on each rising clk edge.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a message is in progress.
- done  output  1  one-cycle pulse when the message completes.

Behaviour:
- Reset (async, rst=1): tx=1, busy=0, done=0; bit counter, byte index and baud counter cleared; state IDLE.
- Reset mid-frame aborts the message. tx returns high immediately, with no glitch low. The aborted message is never resumed.
- IDLE: tx=1, busy=0. If send=1 on edge n:
  - data_in is latched into a 16-bit hold register.
  - byte index is set to 0.
  - state goes to START; busy=1 and tx=0 from edge n+1.
- send while busy=1 is ignored; the latched word is not disturbed.
- data_in changes after the latch edge have no effect on the message.
- Per-byte frame FSM, states START -> DATA -> STOP:
  - START: tx=0 for exactly CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- Baud counter: 16-bit, counts 0..CLKS_PER_BIT-1. It wraps to 0 on each bit boundary and restarts at 0 on every START entry.
- Byte sequencing: byte index 0 = hold[15:8], 1 = hold[7:0], 2 = 8'h0D, 3 = 8'h0A.
  - Last index is 3 if SEND_CRLF=1, otherwise 1.
  - After STOP of a non-last byte, go straight to START of the next byte. No idle gap; the next start bit begins on the cycle after the stop bit ends.
- After STOP of the last byte: state IDLE, busy=0, and done=1 for exactly one cycle, all on the same edge.
  - If send=1 on that same edge, it is not accepted. The earliest accepted request is the following edge, so at least one idle cycle separates messages.
- Message length: (SEND_CRLF ? 4 : 2) × 10 × CLKS_PER_BIT cycles from the first tx low to busy falling.
- Data bytes are sent verbatim; ASCII validity is not checked.
- No internal FIFO: a request arriving while busy is dropped. The upstream counter updates far slower than one message time at default parameters.

Decomposition:
- Shared package (uart_pkg):
  - frame state enum {IDLE, START, DATA, STOP};
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - default CLKS_PER_BIT.
- One sub-module, uart_tx_byte: single-byte 8N1 serializer with baud counter.
  - Interface: clk, rst, start, byte_in[7:0], tx, byte_done.
- The top (ascii_uart_tx) holds:
  - the hold register;
  - the byte-index sequencer (IDLE/SENDING);
  - busy/done generation;
  - the byte mux.

Test Plan:
1. Reset and idle: CLKS_PER_BIT=4, rst pulse, no send for 100 cycles -> tx=1, busy=0, done=0 throughout.
2. Full message, SEND_CRLF=1: data_in=16'h3437 ("47"), send pulse at cycle n.
   - tx low at n+1.
   - UART monitor decodes 0x34, 0x37, 0x0D, 0x0A.
   - busy high for exactly 160 cycles.
   - done pulses once, on the edge busy falls.
3. Two-character mode: SEND_CRLF=0, data_in=16'h3030 -> bytes 0x30, 0x30 only; busy for 80 cycles.
4. Request while busy and data change: send held high during the message; data_in switched to 16'h3939 mid-message.
   - Current message is still "47"+CRLF.
   - Next message starts no earlier than 2 edges after the first done and carries 0x39 0x39.
5. Async reset mid-frame: rst asserted between clk edges during data bit 3 of byte 1 -> tx=1 and busy=0 before the next clk edge; after release, a fresh send transmits a complete, correct message.
6. Bit timing: CLKS_PER_BIT=7 -> every start/data/stop bit lasts exactly 7 cycles (checked by edge timestamps); no gap between a stop bit and the following start bit within the message.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the ASCII UART transmitter.
//   frame_state_t : per-byte 8N1 frame FSM states
//   seq_state_t   : message-level byte sequencer states
//   ascii_pair_t  : two ASCII characters, tens first
//   select_byte   : maps a byte index onto the message byte stream
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;
  localparam int unsigned BAUD_W               = 16;
  localparam int unsigned BYTE_W               = 8;
  localparam int unsigned IDX_W                = 2;

  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } frame_state_t;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_SENDING
  } seq_state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] tens;
    logic [BYTE_W-1:0] ones;
  } ascii_pair_t;

  // Byte stream of one message: tens, ones, CR, LF.
  function automatic logic [BYTE_W-1:0] select_byte(input ascii_pair_t word,
                                                    input logic [IDX_W-1:0] idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = word.tens;
      2'd1:    b = word.ones;
      2'd2:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer with its own baud counter.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : load byte_in and begin a frame (honoured in IDLE or on the
//                last stop-bit cycle, which gives back-to-back frames)
//   byte_in    : byte to send, LSB first
//   tx         : registered serial output, idle high
//   byte_done  : combinational, high on the last cycle of the stop bit
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              tx,
  output logic              byte_done
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  frame_state_t      state;
  frame_state_t      state_nxt;
  logic [BAUD_W-1:0] baud;
  logic [BAUD_W-1:0] baud_nxt;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_idx_nxt;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] shreg_nxt;
  logic              tx_nxt;
  logic              bit_end;
  logic              load;

  assign bit_end   = (baud == BAUD_LAST);
  assign byte_done = (state == STOP) && bit_end;
  // A new frame may begin from IDLE or directly out of the final stop cycle.
  assign load      = start && ((state == IDLE) || byte_done);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      tx      <= tx_nxt;
    end
  end

  // Frame state transitions.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = start ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of tx, baud counter, bit index and shift register.
  always_comb begin
    tx_nxt      = tx;
    baud_nxt    = baud;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    if (load) begin
      tx_nxt      = 1'b0;
      baud_nxt    = '0;
      bit_idx_nxt = '0;
      shreg_nxt   = byte_in;
    end else begin
      case (state)
        IDLE: begin
          tx_nxt   = 1'b1;
          baud_nxt = '0;
        end
        START: begin
          if (bit_end) begin
            baud_nxt = '0;
            tx_nxt   = shreg[0];
          end else begin
            baud_nxt = baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_nxt    = '0;
            bit_idx_nxt = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              tx_nxt = 1'b1;
            end else begin
              // shreg[0] is always the bit currently on the line.
              shreg_nxt = {1'b0, shreg[BYTE_W-1:1]};
              tx_nxt    = shreg[1];
            end
          end else begin
            baud_nxt = baud + BAUD_W'(1);
          end
        end
        STOP: begin
          tx_nxt = 1'b1;
          if (bit_end) begin
            baud_nxt = '0;
          end else begin
            baud_nxt = baud + BAUD_W'(1);
          end
        end
        default: begin
          tx_nxt   = 1'b1;
          baud_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ascii_uart_tx.sv
// Sends a latched two-character ASCII word (optionally followed by CR LF)
// as consecutive 8N1 frames on a single TX line.
//   clk, rst : clock, asynchronous active-high reset
//   data_in  : ASCII pair, [15:8] sent first, [7:0] second
//   send     : request, accepted only while idle
//   tx       : serial line, idle high
//   busy     : high while a message is in progress
//   done     : one-cycle pulse on the edge the message completes
module ascii_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit          SEND_CRLF    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        send,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = SEND_CRLF ? 2'd3 : 2'd1;

  seq_state_t        state;
  seq_state_t        state_nxt;
  ascii_pair_t       hold;
  ascii_pair_t       hold_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              start_c;
  logic [BYTE_W-1:0] byte_c;
  logic              byte_done;
  logic              last_c;

  assign last_c = (idx == LAST_IDX);

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEQ_IDLE;
      hold  <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      idx   <= idx_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Sequencer transitions.
  always_comb begin
    state_nxt = state;
    case (state)
      SEQ_IDLE:    if (send) state_nxt = SEQ_SENDING;
      SEQ_SENDING: if (byte_done && last_c) state_nxt = SEQ_IDLE;
      default:     state_nxt = SEQ_IDLE;
    endcase
  end

  // Byte start/mux, hold register, index, busy and done.
  always_comb begin
    start_c  = 1'b0;
    byte_c   = select_byte(hold, idx + 2'd1);
    hold_nxt = hold;
    idx_nxt  = idx;
    busy_nxt = busy;
    done_nxt = 1'b0;
    case (state)
      SEQ_IDLE: begin
        busy_nxt = 1'b0;
        if (send) begin
          // Hold is not loaded yet, so the first byte comes straight from data_in.
          start_c  = 1'b1;
          byte_c   = data_in[15:8];
          hold_nxt = data_in;
          idx_nxt  = '0;
          busy_nxt = 1'b1;
        end
      end
      SEQ_SENDING: begin
        if (byte_done) begin
          if (last_c) begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
          end else begin
            start_c = 1'b1;
            idx_nxt = idx + 2'd1;
          end
        end
      end
      default: busy_nxt = 1'b0;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .byte_in  (byte_c),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Scoreboarded bench: three ascii_uart_tx instances
//   0: CLKS_PER_BIT=4, CR LF on;  1: CLKS_PER_BIT=4, CR LF off;
//   2: CLKS_PER_BIT=7, CR LF on.
// Stimulus pushes the expected bytes; a negedge monitor decodes frames and pops.
module tb_ascii_uart_tx;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_v   [3];
  logic [15:0] data_v  [3];
  logic        send_v  [3];
  logic        tx_v    [3];
  logic        busy_v  [3];
  logic        done_v  [3];

  int cpb_a [3] = '{4, 4, 7};
  int len_a [3] = '{160, 80, 280};

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  // Monitor state per instance.
  bit         act   [3];
  bit         bprev [3];
  bit         bad   [3];
  logic       bval  [3];
  logic [7:0] sh    [3];
  int         off   [3];
  int         fstart[3];
  int         bstart[3];
  int         done_cyc[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascii_uart_tx #(.CLKS_PER_BIT(4), .SEND_CRLF(1'b1)) u0 (
    .clk(clk), .rst(rst_v[0]), .data_in(data_v[0]), .send(send_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  ascii_uart_tx #(.CLKS_PER_BIT(4), .SEND_CRLF(1'b0)) u1 (
    .clk(clk), .rst(rst_v[1]), .data_in(data_v[1]), .send(send_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  ascii_uart_tx #(.CLKS_PER_BIT(7), .SEND_CRLF(1'b1)) u2 (
    .clk(clk), .rst(rst_v[2]), .data_in(data_v[2]), .send(send_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // Frame decoder, bit-width checker and busy/done checker.
  always @(negedge clk) begin : mon
    int   k;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i] !== 1'b0) begin
        act[i]   = 1'b0;
        bprev[i] = 1'b0;
      end else begin
        if (!bprev[i] && busy_v[i] === 1'b1) begin
          bstart[i] = cyc;
          vectors++;
          if (tx_v[i] !== 1'b0) begin
            errors++;
            $display("FAIL start_low inst%0d: tx=%b when busy rose, need 0", i, tx_v[i]);
          end
        end
        if (bprev[i] && busy_v[i] !== 1'b1) begin
          vectors++;
          done_cyc[i] = cyc;
          if ((cyc - bstart[i]) != len_a[i] || done_v[i] !== 1'b1) begin
            errors++;
            $display("FAIL busy_len inst%0d: busy=%0d cycles done=%b, need %0d cycles done=1",
                     i, cyc - bstart[i], done_v[i], len_a[i]);
          end
        end else if (done_v[i] !== 1'b0) begin
          vectors++;
          errors++;
          $display("FAIL stray_done inst%0d: done=%b at cycle %0d, need 0", i, done_v[i], cyc);
        end
        bprev[i] = (busy_v[i] === 1'b1);

        if (!act[i]) begin
          if (tx_v[i] === 1'b0) begin
            act[i]    = 1'b1;
            off[i]    = 0;
            fstart[i] = cyc;
            bval[i]   = 1'b0;
            bad[i]    = 1'b0;
          end
        end else begin
          off[i]++;
          if (off[i] % cpb_a[i] == 0) begin
            bval[i] = tx_v[i];
            k = off[i] / cpb_a[i];
            if (k >= 1 && k <= 8) sh[i][k-1] = tx_v[i];
          end else if (tx_v[i] !== bval[i]) begin
            bad[i] = 1'b1;
          end
          if (off[i] == 10 * cpb_a[i] - 1) begin
            act[i] = 1'b0;
            vectors++;
            if (bad[i] || bval[i] !== 1'b1 ||
                ((fstart[i] - bstart[i]) % (10 * cpb_a[i])) != 0) begin
              errors++;
              $display("FAIL frame_timing inst%0d: bit_unstable=%b stop=%b offset=%0d, need 0/1/multiple of %0d",
                       i, bad[i], bval[i], fstart[i] - bstart[i], 10 * cpb_a[i]);
            end
            vectors++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL byte inst%0d: got %02h, need no byte", i, sh[i]);
            end else begin
              e = exp_q.pop_front();
              if (32'(e.id) != i || e.b !== sh[i]) begin
                errors++;
                $display("FAIL byte inst%0d: got %02h, need inst%0d byte %02h", i, sh[i], e.id, e.b);
              end
            end
          end
        end
      end
    end
  end

  task automatic do_send(input int i, input logic [15:0] d, input bit crlf);
    @(posedge clk);
    #1;
    data_v[i] = d;
    send_v[i] = 1'b1;
    exp_q.push_back('{id: 2'(i), b: d[15:8]});
    exp_q.push_back('{id: 2'(i), b: d[7:0]});
    if (crlf) begin
      exp_q.push_back('{id: 2'(i), b: 8'h0D});
      exp_q.push_back('{id: 2'(i), b: 8'h0A});
    end
    @(posedge clk);
    #1;
    send_v[i] = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy_v[i] !== 1'b1 || tx_v[i] !== 1'b0) begin
      errors++;
      $display("FAIL accept inst%0d: busy=%b tx=%b, need busy=1 tx=0", i, busy_v[i], tx_v[i]);
    end
  endtask

  task automatic wait_done(input int i, input int lim);
    int n;
    n = 0;
    while (n < lim && done_v[i] !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= lim) begin
      errors++;
      $display("FAIL timeout inst%0d: no done within %0d cycles", i, lim);
    end
  endtask

  initial begin : stim
    bit idle_bad[3];
    for (int i = 0; i < 3; i++) begin
      rst_v[i]  = 1'b1;
      data_v[i] = 16'h0000;
      send_v[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (tx_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: tx=%b busy=%b done=%b, need 1/0/0",
                 i, tx_v[i], busy_v[i], done_v[i]);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;

    // Idle with no request.
    for (int i = 0; i < 3; i++) idle_bad[i] = 1'b0;
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (tx_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) idle_bad[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (idle_bad[i]) begin
        errors++;
        $display("FAIL idle inst%0d: outputs left tx=1 busy=0 done=0", i);
      end
    end

    // Full message with CR LF.
    do_send(0, 16'h3437, 1'b1);
    wait_done(0, 400);
    repeat (5) @(negedge clk);

    // Two-character mode.
    do_send(1, 16'h3030, 1'b0);
    wait_done(1, 200);
    repeat (5) @(negedge clk);

    // 7-cycle bits, non-ASCII data.
    do_send(2, 16'h5AA5, 1'b1);
    wait_done(2, 600);
    repeat (5) @(negedge clk);

    // send held high and data changed mid-message.
    @(posedge clk);
    #1;
    data_v[0] = 16'h3437;
    send_v[0] = 1'b1;
    exp_q.push_back('{id: 2'd0, b: 8'h34});
    exp_q.push_back('{id: 2'd0, b: 8'h37});
    exp_q.push_back('{id: 2'd0, b: 8'h0D});
    exp_q.push_back('{id: 2'd0, b: 8'h0A});
    repeat (60) @(posedge clk);
    #1;
    data_v[0] = 16'h3939;
    exp_q.push_back('{id: 2'd0, b: 8'h39});
    exp_q.push_back('{id: 2'd0, b: 8'h39});
    exp_q.push_back('{id: 2'd0, b: 8'h0D});
    exp_q.push_back('{id: 2'd0, b: 8'h0A});
    wait_done(0, 400);
    @(negedge clk);
    vectors++;
    if (busy_v[0] !== 1'b1 || (cyc - done_cyc[0]) != 1) begin
      errors++;
      $display("FAIL restart_gap: busy=%b gap=%0d, need busy=1 one edge after done",
               busy_v[0], cyc - done_cyc[0]);
    end
    #1;
    send_v[0] = 1'b0;
    wait_done(0, 400);
    repeat (5) @(negedge clk);

    // Async reset during data bit 3 of the first byte.
    do_send(0, 16'h3437, 1'b1);
    repeat (17) @(posedge clk);
    #2;
    rst_v[0] = 1'b1;
    #1;
    vectors++;
    if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tx=%b busy=%b done=%b, need 1/0/0", tx_v[0], busy_v[0], done_v[0]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    do_send(0, 16'h3132, 1'b1);
    wait_done(0, 400);
    repeat (5) @(negedge clk);

    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected bytes never seen, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
